// File: rtl/count_fsm_param_if.sv
// count_fsm_param_if
// Groups the control inputs and status outputs of count_fsm_param into one
// bundle. The clock and reset stay outside the interface as plain ports.
//
// Signals:
//   start, abort, flag          run control (driven by the master)
//   load_val  [CNT_W-1:0]       terminal count, latched on accepted start
//   count_down, auto_reload     run options, latched on accepted start
//   wait_timer [TMR_W-1:0]      post-terminal wait length, latched on start
//   busy, done, timeout         registered status (driven by the slave)
//   count_value [CNT_W-1:0]     registered current count
//   state_o [1:0]               IDLE=0, COUNT=1, WAIT=2
interface count_fsm_param_if #(
  parameter int CNT_W = 8,
  parameter int TMR_W = 8
);
  logic             start;
  logic             abort;
  logic             flag;
  logic [CNT_W-1:0] load_val;
  logic             count_down;
  logic             auto_reload;
  logic [TMR_W-1:0] wait_timer;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] count_value;
  logic [1:0]       state_o;

  modport master (
    output start, abort, flag, load_val, count_down, auto_reload, wait_timer,
    input  busy, done, timeout, count_value, state_o
  );

  modport slave (
    input  start, abort, flag, load_val, count_down, auto_reload, wait_timer,
    output busy, done, timeout, count_value, state_o
  );
endinterface

// File: rtl/count_fsm_param.sv
// count_fsm_param
// Programmable gated counter for timing-window generation. A run counts from
// a start value to an end value (up: 0..tgt, down: tgt..0) while flag is high,
// optionally dwells in a wait window, then pulses done and either returns to
// IDLE or reloads and runs again. A stall watchdog aborts a run whose flag
// stays low for STALL_MAX consecutive COUNT cycles. All outputs are registered.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    count_fsm_param_if.slave: start/abort/flag, run options in,
//          busy/done/timeout/count_value/state_o out
module count_fsm_param #(
  parameter int CNT_W     = 8,
  parameter int TMR_W     = 8,
  parameter int STALL_MAX = 16,
  parameter int STALL_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  count_fsm_param_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [TMR_W-1:0]   TMR_ZERO   = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0]   TMR_ONE    = TMR_W'(1);
  localparam logic [STALL_W-1:0] STALL_ZERO = {STALL_W{1'b0}};
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);
  localparam logic [STALL_W-1:0] STALL_LIM  = STALL_W'(STALL_MAX);
  localparam bit                 STALL_EN   = (STALL_MAX > 0);

  // registered state
  logic [1:0]         state_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   tgt_r;
  logic               dir_r;
  logic               ar_r;
  logic [TMR_W-1:0]   wl_r;
  logic [TMR_W-1:0]   wcnt_r;
  logic [STALL_W-1:0] stall_r;
  logic               busy_r;
  logic               done_r;
  logic               timeout_r;

  // next-state values
  logic [1:0]         state_s;
  logic [CNT_W-1:0]   count_s;
  logic [CNT_W-1:0]   tgt_s;
  logic               dir_s;
  logic               ar_s;
  logic [TMR_W-1:0]   wl_s;
  logic [TMR_W-1:0]   wcnt_s;
  logic [STALL_W-1:0] stall_s;
  logic               done_s;
  logic               timeout_s;
  logic               run_end_s;

  // derived values of the latched run
  logic [CNT_W-1:0]   start_val_s;
  logic [CNT_W-1:0]   end_val_s;
  logic [CNT_W-1:0]   step_val_s;
  logic [TMR_W-1:0]   wcnt_inc_s;
  logic [STALL_W-1:0] stall_inc_s;

  // Start/end points and single-step values for the latched direction
  always_comb begin
    start_val_s = dir_r ? tgt_r : CNT_ZERO;
    end_val_s   = dir_r ? CNT_ZERO : tgt_r;
    step_val_s  = dir_r ? (count_r - CNT_ONE) : (count_r + CNT_ONE);
    wcnt_inc_s  = wcnt_r + TMR_ONE;
    stall_inc_s = stall_r + STALL_ONE;
  end

  // Next-state and output decode: abort beats every normal transition
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    tgt_s     = tgt_r;
    dir_s     = dir_r;
    ar_s      = ar_r;
    wl_s      = wl_r;
    wcnt_s    = wcnt_r;
    stall_s   = stall_r;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    run_end_s = 1'b0;

    if (bus.abort) begin
      // count_value is held; a pending done/timeout is suppressed
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            tgt_s   = bus.load_val;
            dir_s   = bus.count_down;
            ar_s    = bus.auto_reload;
            wl_s    = bus.wait_timer;
            count_s = bus.count_down ? bus.load_val : CNT_ZERO;
            wcnt_s  = TMR_ZERO;
            stall_s = STALL_ZERO;
            state_s = ST_COUNT;
          end else begin
            state_s = ST_IDLE;
          end
        end

        ST_COUNT: begin
          // terminal test comes before the step, so the count never wraps
          if (count_r == end_val_s) begin
            if (wl_r == TMR_ZERO) begin
              run_end_s = 1'b1;
            end else begin
              wcnt_s  = TMR_ZERO;
              state_s = ST_WAIT;
            end
          end else if (bus.flag) begin
            count_s = step_val_s;
            stall_s = STALL_ZERO;
          end else begin
            stall_s = stall_inc_s;
            if (STALL_EN && (stall_inc_s == STALL_LIM)) begin
              timeout_s = 1'b1;
              state_s   = ST_IDLE;
            end else begin
              state_s   = ST_COUNT;
            end
          end
        end

        ST_WAIT: begin
          // exit on the edge where the incremented counter reaches wl,
          // giving exactly wl cycles in WAIT
          wcnt_s = wcnt_inc_s;
          if (wcnt_inc_s == wl_r) begin
            run_end_s = 1'b1;
          end else begin
            state_s = ST_WAIT;
          end
        end

        default: begin
          state_s = ST_IDLE;
        end
      endcase

      if (run_end_s) begin
        done_s = 1'b1;
        if (ar_r) begin
          state_s = ST_COUNT;
          count_s = start_val_s;
          stall_s = STALL_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end else begin
        done_s = 1'b0;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      count_r   <= CNT_ZERO;
      tgt_r     <= CNT_ZERO;
      dir_r     <= 1'b0;
      ar_r      <= 1'b0;
      wl_r      <= TMR_ZERO;
      wcnt_r    <= TMR_ZERO;
      stall_r   <= STALL_ZERO;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      tgt_r     <= tgt_s;
      dir_r     <= dir_s;
      ar_r      <= ar_s;
      wl_r      <= wl_s;
      wcnt_r    <= wcnt_s;
      stall_r   <= stall_s;
      busy_r    <= (state_s != ST_IDLE);
      done_r    <= done_s;
      timeout_r <= timeout_s;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.timeout     = timeout_r;
  assign bus.count_value = count_r;
  assign bus.state_o     = state_r;

endmodule

// File: tb/tb_count_fsm_param.sv
// Testbench for count_fsm_param. Two instances share one stimulus stream:
// dut0 with the watchdog at 16, dut1 with the watchdog disabled. A run-level
// reference model (steps taken, wait cycles, stall run length) predicts the
// outputs of both every cycle; directed sections pin the model with literal
// expectations, then a randomized section exercises the rest.
module tb_count_fsm_param;
  localparam int CW = 8;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, abort = 1'b0, flag = 1'b0, cd = 1'b0, ar = 1'b0;
  logic [CW-1:0] load = '0;
  logic [TW-1:0] wt = '0;

  count_fsm_param_if #(.CNT_W(CW), .TMR_W(TW)) bus0 ();
  count_fsm_param_if #(.CNT_W(CW), .TMR_W(TW)) bus1 ();

  assign bus0.start = start;       assign bus1.start = start;
  assign bus0.abort = abort;       assign bus1.abort = abort;
  assign bus0.flag = flag;         assign bus1.flag = flag;
  assign bus0.load_val = load;     assign bus1.load_val = load;
  assign bus0.count_down = cd;     assign bus1.count_down = cd;
  assign bus0.auto_reload = ar;    assign bus1.auto_reload = ar;
  assign bus0.wait_timer = wt;     assign bus1.wait_timer = wt;

  count_fsm_param #(.CNT_W(CW), .TMR_W(TW), .STALL_MAX(16), .STALL_W(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  count_fsm_param #(.CNT_W(CW), .TMR_W(TW), .STALL_MAX(0), .STALL_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int smax[2] = '{16, 0};
  int m_act[2], m_wait[2], m_steps[2], m_wcnt[2], m_stall[2];
  int m_tgt[2], m_dir[2], m_ar[2], m_wl[2], m_done[2], m_to[2];

  task automatic m_finish(input int k);
    m_done[k] = 1;
    if (m_ar[k] != 0) begin
      m_wait[k] = 0; m_steps[k] = 0; m_stall[k] = 0;
    end else begin
      m_act[k] = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0; m_to[k] = 0;
      if (!rst_n) begin
        m_act[k] = 0; m_wait[k] = 0; m_steps[k] = 0; m_wcnt[k] = 0; m_stall[k] = 0;
        m_tgt[k] = 0; m_dir[k] = 0; m_ar[k] = 0; m_wl[k] = 0;
      end else if (abort) begin
        m_act[k] = 0;
      end else if (m_act[k] == 0) begin
        if (start) begin
          m_tgt[k] = int'(load); m_dir[k] = int'(cd); m_ar[k] = int'(ar); m_wl[k] = int'(wt);
          m_act[k] = 1; m_wait[k] = 0; m_steps[k] = 0; m_stall[k] = 0;
        end
      end else if (m_wait[k] != 0) begin
        m_wcnt[k]++;
        if (m_wcnt[k] == m_wl[k]) m_finish(k);
      end else if (m_steps[k] == m_tgt[k]) begin
        if (m_wl[k] == 0) m_finish(k);
        else begin m_wait[k] = 1; m_wcnt[k] = 0; end
      end else if (flag) begin
        m_steps[k]++; m_stall[k] = 0;
      end else begin
        m_stall[k]++;
        if (smax[k] > 0 && m_stall[k] == smax[k]) begin m_to[k] = 1; m_act[k] = 0; end
      end
    end
  end

  function automatic logic [12:0] mexp(input int k);
    int c;
    logic [1:0] st;
    c = (m_dir[k] != 0) ? (m_tgt[k] - m_steps[k]) : m_steps[k];
    st = (m_act[k] == 0) ? 2'd0 : ((m_wait[k] != 0) ? 2'd2 : 2'd1);
    return {m_act[k] != 0, m_done[k] != 0, m_to[k] != 0, st, c[7:0]};
  endfunction

  logic [12:0] obs0, obs1;
  assign obs0 = {bus0.busy, bus0.done, bus0.timeout, bus0.state_o, bus0.count_value};
  assign obs1 = {bus1.busy, bus1.done, bus1.timeout, bus1.state_o, bus1.count_value};

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("model_dut0", obs0, mexp(0));
      chk("model_dut1", obs1, mexp(1));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int bc, dn, n, lowrun;
    logic [31:0] seq, dmask;
    logic [5:0] fp;
    bit saw_wait, allbusy;

    rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_dut0", obs0, 32'h0);
    chk("reset_dut1", obs1, 32'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // up count 0..3 with a 2-cycle wait
    load = 8'd3; cd = 1'b0; wt = 8'd2; ar = 1'b0; flag = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    bc = 0; seq = 32'h0;
    for (int i = 0; i < 40 && bus0.busy; i++) begin
      if (i < 4) seq = (seq << 8) | 32'(bus0.count_value);
      bc++;
      tick();
    end
    chk("t1_seq", seq, 32'h00010203);
    chk("t1_busy_cycles", bc, 32'd6);
    chk("t1_done_at_fall", {bus0.done, bus0.count_value}, {1'b1, 8'd3});
    tick();
    chk("t1_done_single", {bus0.done, bus0.busy, bus0.count_value}, {1'b0, 1'b0, 8'd3});

    // down count with flag gaps, no wait window
    load = 8'd4; cd = 1'b1; wt = 8'd0; flag = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    fp = 6'b111001; seq = 32'h0; saw_wait = 1'b0;
    for (int i = 0; i < 7; i++) begin
      seq = (seq << 4) | 32'(bus0.count_value[3:0]);
      if (bus0.state_o == 2'd2) saw_wait = 1'b1;
      if (i < 6) flag = fp[i];
      tick();
    end
    chk("t2_seq", seq, 32'h04333210);
    chk("t2_no_wait", {31'd0, saw_wait}, 32'd0);
    chk("t2_done", {bus0.done, bus0.busy, bus0.state_o, bus0.count_value}, {1'b1, 1'b0, 2'd0, 8'd0});

    // stall watchdog: dut0 fires after 16 low cycles, dut1 never does
    load = 8'd10; cd = 1'b0; wt = 8'd0; ar = 1'b0; flag = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("t3_cnt2", bus0.count_value, 32'd2);
    flag = 1'b0; n = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (bus0.done) dn++;
      if (bus0.timeout) break;
    end
    chk("t3_stall_cycles", n, 32'd16);
    chk("t3_timeout", {bus0.timeout, bus0.busy, bus0.done, bus0.count_value}, {1'b1, 1'b0, 1'b0, 8'd2});
    chk("t3_no_done", dn, 32'd0);
    repeat (20) tick();
    chk("t3_nowd_count", {bus1.busy, bus1.state_o, bus1.count_value}, {1'b1, 2'd1, 8'd2});
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t3_abort", {bus1.busy, bus1.done, bus1.state_o, bus1.count_value}, {1'b0, 1'b0, 2'd0, 8'd2});

    // auto-reload: done every 4 cycles, then abort with no done
    load = 8'd2; cd = 1'b0; wt = 8'd1; ar = 1'b1; flag = 1'b1; start = 1'b1;
    tick(); start = 1'b0; ar = 1'b0; wt = 8'd7;
    dmask = 32'h0; allbusy = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (bus0.done) dmask = dmask | (32'd1 << i);
      if (!bus0.busy) allbusy = 1'b0;
      if (i < 12) tick();
    end
    chk("t4_done_pos", dmask, 32'h220);
    chk("t4_busy", {31'd0, allbusy}, 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_abort", {bus0.busy, bus0.done, bus0.state_o}, {1'b0, 1'b0, 2'd0});

    // tgt=0, wl=0 with start held: one-cycle runs back to back
    load = 8'd0; cd = 1'b0; wt = 8'd0; ar = 1'b0; start = 1'b1;
    tick();
    chk("t5_run1", {bus0.busy, bus0.done, bus0.state_o}, {1'b1, 1'b0, 2'd1});
    tick();
    chk("t5_done1", {bus0.busy, bus0.done, bus0.state_o}, {1'b0, 1'b1, 2'd0});
    tick();
    chk("t5_run2", {bus0.busy, bus0.done, bus0.state_o}, {1'b1, 1'b0, 2'd1});
    start = 1'b0;
    tick();
    chk("t5_done2", {bus0.busy, bus0.done, bus0.count_value}, {1'b0, 1'b1, 8'd0});

    // reset in WAIT, then abort+start together in IDLE
    load = 8'd1; cd = 1'b0; wt = 8'd5; flag = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("t6_in_wait", bus0.state_o, 32'd2);
    rst_n = 1'b0; tick();
    chk("t6_reset0", obs0, 32'h0);
    chk("t6_reset1", obs1, 32'h0);
    rst_n = 1'b1;
    abort = 1'b1; start = 1'b1; load = 8'd5;
    tick();
    chk("t6_abort_start", obs0, 32'h0);
    abort = 1'b0; start = 1'b0;

    // randomized phase
    lowrun = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      abort = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 3) == 0);
      if (lowrun > 0) begin
        flag = 1'b0; lowrun--;
      end else begin
        flag = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 149) == 0) lowrun = $urandom_range(10, 24);
      end
      load = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      cd = 1'($urandom_range(0, 1));
      ar = ($urandom_range(0, 3) == 0);
      wt = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 3));
      tick();
    end
    rst_n = 1'b1; abort = 1'b0; start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
